// File: rtl/mem_access_master_if.sv
// mem_access_master_if: fetch, load/store and memory-port signals of mem_access_master.
// The master modport is the view taken by mem_access_master itself.
interface mem_access_master_if;
  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic        o_if_gnt;
  logic        o_if_valid;
  logic [31:0] o_if_instr;
  logic        i_ls_req;
  logic        i_ls_we;
  logic [1:0]  i_ls_size;
  logic        i_ls_sext;
  logic [31:0] i_ls_addr;
  logic [31:0] i_ls_wdata;
  logic        o_ls_gnt;
  logic        o_ls_valid;
  logic [31:0] o_ls_rdata;
  logic        o_ls_err;
  logic [31:0] o_mem_addr;
  logic        o_mem_we;
  logic [31:0] o_mem_wdata;
  logic [31:0] i_mem_rdata;
  logic        o_busy;

  modport master (
    input  i_if_req, i_if_addr, i_ls_req, i_ls_we, i_ls_size, i_ls_sext,
           i_ls_addr, i_ls_wdata, i_mem_rdata,
    output o_if_gnt, o_if_valid, o_if_instr, o_ls_gnt, o_ls_valid, o_ls_rdata,
           o_ls_err, o_mem_addr, o_mem_we, o_mem_wdata, o_busy
  );

  modport slave (
    output i_if_req, i_if_addr, i_ls_req, i_ls_we, i_ls_size, i_ls_sext,
           i_ls_addr, i_ls_wdata, i_mem_rdata,
    input  o_if_gnt, o_if_valid, o_if_instr, o_ls_gnt, o_ls_valid, o_ls_rdata,
           o_ls_err, o_mem_addr, o_mem_we, o_mem_wdata, o_busy
  );
endinterface

// File: rtl/mem_access_master.sv
// mem_access_master: arbitrates instruction fetch and load/store onto a single
// word-wide memory port. Sub-word stores become read-modify-write sequences and
// sub-word loads are lane-extracted and sign/zero-extended.
module mem_access_master #(
  parameter bit LS_PRIORITY = 1'b1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  mem_access_master_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WRITE  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nx;

  logic        r_own_ls;
  logic        r_we;
  logic        r_sext;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_base;
  logic [31:0] r_mem_addr;
  logic [31:0] r_if_instr;
  logic [31:0] r_ls_rdata;
  logic        r_if_valid;
  logic        r_ls_valid;
  logic        r_ls_err;

  logic        w_take_ls;
  logic        w_take_if;
  logic        w_ls_misal;
  logic        w_word_store;
  logic        w_if_gnt;
  logic        w_ls_gnt;
  logic        w_mem_we;
  logic [31:0] w_mem_wdata;
  logic        w_unused;

  // Replace the addressed byte (size 00) or halfword lane of base with data.
  function automatic logic [31:0] merge_lane(input logic [31:0] base, input logic [31:0] data,
                                             input logic [1:0] size, input logic [1:0] lane);
    logic [31:0] res;
    res = base;
    if (size == 2'b00) begin
      case (lane)
        2'd0:    res[7:0]   = data[7:0];
        2'd1:    res[15:8]  = data[7:0];
        2'd2:    res[23:16] = data[7:0];
        default: res[31:24] = data[7:0];
      endcase
    end else begin
      if (lane[1]) res[31:16] = data[15:0];
      else         res[15:0]  = data[15:0];
    end
    return res;
  endfunction

  // Pick the addressed lane out of a memory word and extend it to 32 bits.
  function automatic logic [31:0] extract_lane(input logic [31:0] word, input logic [1:0] size,
                                               input logic sext, input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   res = {{24{sext & b[7]}}, b};
      2'b01:   res = {{16{sext & h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  // Fetch byte offset is meaningless: fetches are always word aligned.
  assign w_unused = ^bus.i_if_addr[1:0];

  assign w_ls_misal   = (bus.i_ls_size == 2'b01) ? bus.i_ls_addr[0]
                      : (bus.i_ls_size[1] ? (bus.i_ls_addr[1:0] != 2'b00) : 1'b0);
  assign w_take_ls    = bus.i_ls_req & (LS_PRIORITY | ~bus.i_if_req);
  assign w_take_if    = bus.i_if_req & ~w_take_ls;
  assign w_word_store = r_own_ls & r_we & r_size[1];

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nx;
  end

  // Next-state decode plus combinational grants and memory write controls.
  always_comb begin
    w_state_nx  = r_state;
    w_if_gnt    = 1'b0;
    w_ls_gnt    = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_wdata = 32'h0000_0000;
    case (r_state)
      S_IDLE: begin
        // Grants are held low while reset is asserted so every output reads 0.
        if (i_rst_n && w_take_ls) begin
          w_ls_gnt   = 1'b1;
          w_state_nx = w_ls_misal ? S_DONE : S_ACCESS;
        end else if (i_rst_n && w_take_if) begin
          w_if_gnt   = 1'b1;
          w_state_nx = S_ACCESS;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      S_ACCESS: begin
        if (r_own_ls && r_we && !r_size[1]) w_state_nx = S_WRITE;
        else                                w_state_nx = S_DONE;
        if (w_word_store) begin
          w_mem_we    = 1'b1;
          w_mem_wdata = r_wdata;
        end else begin
          w_mem_we    = 1'b0;
          w_mem_wdata = 32'h0000_0000;
        end
      end
      S_WRITE: begin
        w_mem_we    = 1'b1;
        w_mem_wdata = merge_lane(r_base, r_wdata, r_size, r_addr[1:0]);
        w_state_nx  = S_DONE;
      end
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Request capture, read data capture and registered response pulses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_own_ls   <= 1'b0;
      r_we       <= 1'b0;
      r_sext     <= 1'b0;
      r_size     <= 2'b00;
      r_addr     <= 32'h0000_0000;
      r_wdata    <= 32'h0000_0000;
      r_base     <= 32'h0000_0000;
      r_mem_addr <= 32'h0000_0000;
      r_if_instr <= 32'h0000_0000;
      r_ls_rdata <= 32'h0000_0000;
      r_if_valid <= 1'b0;
      r_ls_valid <= 1'b0;
      r_ls_err   <= 1'b0;
    end else begin
      r_if_valid <= 1'b0;
      r_ls_valid <= 1'b0;
      r_ls_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_ls_gnt) begin
            r_own_ls <= 1'b1;
            r_we     <= bus.i_ls_we;
            r_size   <= bus.i_ls_size;
            r_sext   <= bus.i_ls_sext;
            r_addr   <= bus.i_ls_addr;
            r_wdata  <= bus.i_ls_wdata;
            if (w_ls_misal) begin
              // Misaligned: answer straight away, memory port untouched.
              r_ls_valid <= 1'b1;
              r_ls_err   <= 1'b1;
            end else begin
              r_mem_addr <= {bus.i_ls_addr[31:2], 2'b00};
            end
          end else if (w_if_gnt) begin
            r_own_ls   <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= {bus.i_if_addr[31:2], 2'b00};
            r_mem_addr <= {bus.i_if_addr[31:2], 2'b00};
          end
        end
        S_ACCESS: begin
          if (!r_own_ls) begin
            r_if_instr <= bus.i_mem_rdata;
            r_if_valid <= 1'b1;
          end else if (!r_we) begin
            r_ls_rdata <= extract_lane(bus.i_mem_rdata, r_size, r_sext, r_addr[1:0]);
            r_ls_valid <= 1'b1;
          end else if (r_size[1]) begin
            r_ls_valid <= 1'b1;
          end else begin
            r_base <= bus.i_mem_rdata;
          end
        end
        S_WRITE: r_ls_valid <= 1'b1;
        default: r_ls_valid <= 1'b0;
      endcase
    end
  end

  assign bus.o_if_gnt    = w_if_gnt;
  assign bus.o_if_valid  = r_if_valid;
  assign bus.o_if_instr  = r_if_instr;
  assign bus.o_ls_gnt    = w_ls_gnt;
  assign bus.o_ls_valid  = r_ls_valid;
  assign bus.o_ls_rdata  = r_ls_rdata;
  assign bus.o_ls_err    = r_ls_err;
  assign bus.o_mem_addr  = r_mem_addr;
  assign bus.o_mem_we    = w_mem_we;
  assign bus.o_mem_wdata = w_mem_wdata;
  assign bus.o_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_access_master.sv
// tb_mem_access_master: drives mem_access_master against a word memory and
// compares responses and memory contents with a transaction-level reference.
module tb_mem_access_master;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic        mem_load = 1'b0;
  int          we_cnt = 0;
  logic [31:0] last_we_addr = 32'h0;

  always #5 clk = ~clk;

  mem_access_master_if bus ();
  mem_access_master_if bus0 ();

  mem_access_master #(.LS_PRIORITY(1'b1)) dut  (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
  mem_access_master #(.LS_PRIORITY(1'b0)) dut0 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus0));

  assign bus.i_mem_rdata  = mem[bus.o_mem_addr[11:2]];
  assign bus0.i_mem_rdata = mem[bus0.o_mem_addr[11:2]];

  // Memory write port (and bulk preload from the reference image).
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 1024; i++) mem[i] <= ref_mem[i];
    end else if (bus.o_mem_we) begin
      mem[bus.o_mem_addr[11:2]] <= bus.o_mem_wdata;
      we_cnt       <= we_cnt + 1;
      last_we_addr <= bus.o_mem_addr;
    end
  end

  // Reference: value a load returns from word w.
  function automatic logic [31:0] exp_load(input logic [31:0] w, input logic [1:0] sz,
                                           input logic sx, input logic [31:0] a);
    logic [31:0] v;
    if (sz == 2'b00) begin
      v = (w >> (8 * int'(a[1:0]))) & 32'h0000_00FF;
      if (sx && v >= 32'd128) v = v + 32'hFFFF_FF00;
    end else if (sz == 2'b01) begin
      v = (w >> (16 * int'(a[1]))) & 32'h0000_FFFF;
      if (sx && v >= 32'd32768) v = v + 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  // Reference: word w after a store of d.
  function automatic logic [31:0] exp_store(input logic [31:0] w, input logic [1:0] sz,
                                            input logic [31:0] a, input logic [31:0] d);
    logic [31:0] m;
    int sh;
    if (sz == 2'b00) begin
      sh = 8 * int'(a[1:0]);
      m  = 32'h0000_00FF << sh;
      return (w & ~m) | ((d & 32'h0000_00FF) << sh);
    end else if (sz == 2'b01) begin
      sh = 16 * int'(a[1]);
      m  = 32'h0000_FFFF << sh;
      return (w & ~m) | ((d & 32'h0000_FFFF) << sh);
    end
    return d;
  endfunction

  function automatic logic exp_misal(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'b01) return (a % 2) != 0;
    if (sz >= 2'b10) return (a % 4) != 0;
    return 1'b0;
  endfunction

  // Issue one load/store; lat = cycles from gnt to valid (-1 if never granted).
  task automatic ls_txn(input logic we, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
    int n;
    @(negedge clk);
    bus.i_ls_req = 1'b1; bus.i_ls_we = we; bus.i_ls_size = sz;
    bus.i_ls_sext = sx; bus.i_ls_addr = a; bus.i_ls_wdata = wd;
    #1;
    n = 0;
    while (bus.o_ls_gnt !== 1'b1 && n < 20) begin @(negedge clk); #1; n++; end
    @(posedge clk); #1;
    bus.i_ls_req = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk); lat++;
      if (bus.o_ls_valid === 1'b1) break;
    end
    rd = bus.o_ls_rdata;
    er = bus.o_ls_err;
    if (n >= 20) lat = -1;
  endtask

  // Issue one fetch.
  task automatic if_txn(input logic [31:0] a, output logic [31:0] instr, output int lat);
    int n;
    @(negedge clk);
    bus.i_if_req = 1'b1; bus.i_if_addr = a;
    #1;
    n = 0;
    while (bus.o_if_gnt !== 1'b1 && n < 20) begin @(negedge clk); #1; n++; end
    @(posedge clk); #1;
    bus.i_if_req = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk); lat++;
      if (bus.o_if_valid === 1'b1) break;
    end
    instr = bus.o_if_instr;
    if (n >= 20) lat = -1;
  endtask

  task automatic test_reset();
    logic [134:0] outs;
    #1 rst_n = 1'b0;
    #1;
    outs = {bus.o_if_gnt, bus.o_if_valid, bus.o_if_instr, bus.o_ls_gnt, bus.o_ls_valid,
            bus.o_ls_rdata, bus.o_ls_err, bus.o_mem_addr, bus.o_mem_we, bus.o_mem_wdata, bus.o_busy};
    checks++;
    if (outs !== 135'd0) begin errors++; $display("FAIL reset_outputs got %h want 0", outs); end
    mem_load = 1'b1;
    repeat (2) @(posedge clk);
    #1 mem_load = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    // Mid-stream reset while a load is in ACCESS, request still held high.
    @(negedge clk);
    bus.i_ls_req = 1'b1; bus.i_ls_we = 1'b0; bus.i_ls_size = 2'b10;
    bus.i_ls_sext = 1'b0; bus.i_ls_addr = 32'h0000_0404; bus.i_ls_wdata = 32'h0;
    @(posedge clk); #2;
    checks++;
    if ({bus.o_busy, bus.o_mem_addr} !== {1'b1, 32'h0000_0404})
      begin errors++; $display("FAIL midreset_pre got busy=%b addr=%h want 1 00000404", bus.o_busy, bus.o_mem_addr); end
    rst_n = 1'b0;
    #1;
    outs = {bus.o_if_gnt, bus.o_if_valid, bus.o_if_instr, bus.o_ls_gnt, bus.o_ls_valid,
            bus.o_ls_rdata, bus.o_ls_err, bus.o_mem_addr, bus.o_mem_we, bus.o_mem_wdata, bus.o_busy};
    checks++;
    if (outs !== 135'd0) begin errors++; $display("FAIL midreset_outputs got %h want 0", outs); end
    @(negedge clk) bus.i_ls_req = 1'b0;
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_word_roundtrip();
    logic [31:0] rd; logic er; int lat; int w0;
    w0 = we_cnt;
    ls_txn(1'b1, 2'b10, 1'b0, 32'h0000_0404, 32'hDEAD_BEEF, rd, er, lat);
    ref_mem[257] = exp_store(ref_mem[257], 2'b10, 32'h0000_0404, 32'hDEAD_BEEF);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL word_store_lat got %0d want 2", lat); end
    checks++;
    if (we_cnt - w0 !== 1) begin errors++; $display("FAIL word_store_we_cycles got %0d want 1", we_cnt - w0); end
    checks++;
    if (last_we_addr !== 32'h0000_0404) begin errors++; $display("FAIL word_store_addr got %h want 00000404", last_we_addr); end
    checks++;
    if (mem[257] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL word_store_mem got %h want deadbeef", mem[257]); end
    ls_txn(1'b0, 2'b10, 1'b0, 32'h0000_0404, 32'h0, rd, er, lat);
    checks++;
    if ({rd, er} !== {32'hDEAD_BEEF, 1'b0}) begin errors++; $display("FAIL word_load got %h err=%b want deadbeef 0", rd, er); end
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL word_load_lat got %0d want 2", lat); end
  endtask

  task automatic test_subword();
    logic [31:0] rd; logic er; int lat; int w0;
    w0 = we_cnt;
    ls_txn(1'b1, 2'b00, 1'b0, 32'h0000_0405, 32'h1234_56AA, rd, er, lat);
    ref_mem[257] = exp_store(ref_mem[257], 2'b00, 32'h0000_0405, 32'h1234_56AA);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL byte_store_lat got %0d want 3", lat); end
    checks++;
    if (we_cnt - w0 !== 1) begin errors++; $display("FAIL byte_store_we_cycles got %0d want 1", we_cnt - w0); end
    checks++;
    if (mem[257] !== 32'hDEAD_AAEF) begin errors++; $display("FAIL byte_store_mem got %h want deadaaef", mem[257]); end
    ls_txn(1'b0, 2'b00, 1'b1, 32'h0000_0405, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'hFFFF_FFAA) begin errors++; $display("FAIL byte_load_signed got %h want ffffffaa", rd); end
    ls_txn(1'b0, 2'b00, 1'b0, 32'h0000_0405, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h0000_00AA) begin errors++; $display("FAIL byte_load_unsigned got %h want 000000aa", rd); end
    ls_txn(1'b0, 2'b01, 1'b1, 32'h0000_0406, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'hFFFF_DEAD) begin errors++; $display("FAIL half_load_signed got %h want ffffdead", rd); end
  endtask

  task automatic test_misaligned();
    logic [31:0] rd; logic er; int lat; int w0;
    w0 = we_cnt;
    ls_txn(1'b1, 2'b01, 1'b0, 32'h0000_0403, 32'h0000_5555, rd, er, lat);
    checks++;
    if ({lat == 1, er} !== 2'b11) begin errors++; $display("FAIL misal_store got lat=%0d err=%b want 1 1", lat, er); end
    checks++;
    if (we_cnt - w0 !== 0) begin errors++; $display("FAIL misal_store_we got %0d want 0", we_cnt - w0); end
    ls_txn(1'b0, 2'b10, 1'b0, 32'h0000_0402, 32'h0, rd, er, lat);
    checks++;
    if ({lat == 1, er} !== 2'b11) begin errors++; $display("FAIL misal_load got lat=%0d err=%b want 1 1", lat, er); end
  endtask

  task automatic test_conflict();
    int k_lv = -1, k_ig = -1, k_iv = -1, k0_iv = -1, k0_lg = -1;
    logic [31:0] instr = 32'h0;
    @(negedge clk);
    bus.i_if_req = 1'b1; bus.i_if_addr = 32'h0000_0406;
    bus.i_ls_req = 1'b1; bus.i_ls_we = 1'b0; bus.i_ls_size = 2'b10; bus.i_ls_sext = 1'b0; bus.i_ls_addr = 32'h0000_0404;
    bus0.i_if_req = 1'b1; bus0.i_if_addr = 32'h0000_0406;
    bus0.i_ls_req = 1'b1; bus0.i_ls_we = 1'b0; bus0.i_ls_size = 2'b10; bus0.i_ls_sext = 1'b0; bus0.i_ls_addr = 32'h0000_0404;
    #1;
    checks++;
    if ({bus.o_ls_gnt, bus.o_if_gnt} !== 2'b10) begin errors++; $display("FAIL conflict_ls_prio got ls/if=%b%b want 10", bus.o_ls_gnt, bus.o_if_gnt); end
    checks++;
    if ({bus0.o_ls_gnt, bus0.o_if_gnt} !== 2'b01) begin errors++; $display("FAIL conflict_if_prio got ls/if=%b%b want 01", bus0.o_ls_gnt, bus0.o_if_gnt); end
    @(posedge clk); #1;
    bus.i_ls_req = 1'b0; bus0.i_if_req = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk); #1;
      if (bus.o_ls_valid === 1'b1 && k_lv < 0) k_lv = k;
      if (bus.o_if_gnt === 1'b1 && k_ig < 0) k_ig = k;
      if (bus.o_if_valid === 1'b1 && k_iv < 0) begin k_iv = k; instr = bus.o_if_instr; end
      if (bus0.o_if_valid === 1'b1 && k0_iv < 0) k0_iv = k;
      if (bus0.o_ls_gnt === 1'b1 && k0_lg < 0) k0_lg = k;
      @(posedge clk); #1;
      if (k_ig == k) bus.i_if_req = 1'b0;
      if (k0_lg == k) bus0.i_ls_req = 1'b0;
    end
    bus.i_if_req = 1'b0; bus0.i_ls_req = 1'b0;
    checks++;
    if (k_lv != 2 || k_ig != 3) begin errors++; $display("FAIL conflict_order_ls got valid@%0d gnt@%0d want 2 3", k_lv, k_ig); end
    checks++;
    if (k0_iv != 2 || k0_lg != 3) begin errors++; $display("FAIL conflict_order_if got valid@%0d gnt@%0d want 2 3", k0_iv, k0_lg); end
    checks++;
    if (k_iv != 5 || instr !== ref_mem[257]) begin errors++; $display("FAIL conflict_fetch got @%0d %h want 5 %h", k_iv, instr, ref_mem[257]); end
  endtask

  task automatic test_abort();
    @(negedge clk);
    bus.i_ls_req = 1'b1; bus.i_ls_we = 1'b1; bus.i_ls_size = 2'b01; bus.i_ls_sext = 1'b0;
    bus.i_ls_addr = 32'h0000_0404; bus.i_ls_wdata = 32'h0000_1234;
    @(posedge clk); #1 bus.i_ls_req = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    checks++;
    if (bus.o_mem_we !== 1'b1) begin errors++; $display("FAIL abort_in_write got we=%b want 1", bus.o_mem_we); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.o_busy, bus.o_mem_we} !== 2'b00) begin errors++; $display("FAIL abort_reset got busy/we=%b%b want 00", bus.o_busy, bus.o_mem_we); end
    @(posedge clk); #1;
    checks++;
    if (mem[257] !== ref_mem[257]) begin errors++; $display("FAIL abort_mem got %h want %h", mem[257], ref_mem[257]); end
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL abort_idle got busy=%b want 0", bus.o_busy); end
  endtask

  task automatic test_random();
    logic [31:0] a, d, rd; logic [1:0] sz; logic sx, er, mis; int lat, w0, op, idx, bad;
    for (int it = 0; it < 60; it++) begin
      op = $urandom_range(0, 2);
      sz = 2'($urandom_range(0, 3));
      sx = 1'($urandom_range(0, 1));
      d  = $urandom;
      a  = $urandom_range(0, 4095);
      if ($urandom_range(0, 3) != 0) a = (sz == 2'b01) ? (a & 32'hFFFF_FFFE) : ((sz == 2'b00) ? a : (a & 32'hFFFF_FFFC));
      idx = int'(a / 4);
      mis = exp_misal(sz, a);
      w0  = we_cnt;
      if (op == 0) begin
        if_txn(a, rd, lat);
        checks++;
        if (lat != 2 || rd !== ref_mem[idx]) begin errors++; $display("FAIL rnd_fetch @%h got lat=%0d %h want 2 %h", a, lat, rd, ref_mem[idx]); end
      end else if (op == 1) begin
        ls_txn(1'b0, sz, sx, a, d, rd, er, lat);
        checks++;
        if (er !== mis || lat != (mis ? 1 : 2)) begin errors++; $display("FAIL rnd_load_ctl @%h sz=%0d got err=%b lat=%0d want %b %0d", a, sz, er, lat, mis, mis ? 1 : 2); end
        if (!mis) begin
          checks++;
          if (rd !== exp_load(ref_mem[idx], sz, sx, a)) begin errors++; $display("FAIL rnd_load_data @%h sz=%0d sx=%b got %h want %h", a, sz, sx, rd, exp_load(ref_mem[idx], sz, sx, a)); end
        end
      end else begin
        ls_txn(1'b1, sz, sx, a, d, rd, er, lat);
        if (!mis) ref_mem[idx] = exp_store(ref_mem[idx], sz, a, d);
        checks++;
        if (er !== mis || lat != (mis ? 1 : (sz >= 2'b10 ? 2 : 3)) || (we_cnt - w0) != (mis ? 0 : 1))
          begin errors++; $display("FAIL rnd_store_ctl @%h sz=%0d got err=%b lat=%0d we=%0d want err=%b", a, sz, er, lat, we_cnt - w0, mis); end
        checks++;
        if (mem[idx] !== ref_mem[idx]) begin errors++; $display("FAIL rnd_store_mem @%h got %h want %h", a, mem[idx], ref_mem[idx]); end
      end
    end
    bad = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL mem_image got %0d differing words want 0", bad); end
  endtask

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_if_req = 1'b0; bus.i_if_addr = 32'h0; bus.i_ls_req = 1'b0; bus.i_ls_we = 1'b0;
    bus.i_ls_size = 2'b00; bus.i_ls_sext = 1'b0; bus.i_ls_addr = 32'h0; bus.i_ls_wdata = 32'h0;
    bus0.i_if_req = 1'b0; bus0.i_if_addr = 32'h0; bus0.i_ls_req = 1'b0; bus0.i_ls_we = 1'b0;
    bus0.i_ls_size = 2'b00; bus0.i_ls_sext = 1'b0; bus0.i_ls_addr = 32'h0; bus0.i_ls_wdata = 32'h0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = $urandom;
    test_reset();
    test_word_roundtrip();
    test_subword();
    test_misaligned();
    test_conflict();
    test_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
